// File: rtl/guess_game_nd_pkg.sv
// Shared types and helpers for the N-digit bulls-and-cows game.
package guess_game_nd_pkg;

    // Game flow states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_EVAL = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_t;

    function automatic int min_int(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/guess_game_nd_score.sv
// Combinational scorer: A = exact position matches, B = common digits
// (counted with multiplicity through per-value histograms) minus A.
module guess_game_nd_score
    import guess_game_nd_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic [DIGITS*DIGIT_W-1:0]   secret_flat,
    input  logic [DIGITS*DIGIT_W-1:0]   guess_flat,
    output logic [$clog2(DIGITS+1)-1:0] a_cnt,
    output logic [$clog2(DIGITS+1)-1:0] b_cnt
);

    localparam int CW   = $clog2(DIGITS + 1);
    localparam int BINS = 1 << DIGIT_W;

    int a_int;
    int m_int;
    int cs;
    int cg;

    // Exact matches, then sum of min(histogram_secret, histogram_guess) over all values.
    always_comb begin
        a_int = 0;
        m_int = 0;
        cs    = 0;
        cg    = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (secret_flat[i*DIGIT_W +: DIGIT_W] == guess_flat[i*DIGIT_W +: DIGIT_W])
                a_int = a_int + 1;
        end
        for (int v = 0; v < BINS; v++) begin
            cs = 0;
            cg = 0;
            for (int i = 0; i < DIGITS; i++) begin
                if (secret_flat[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v))
                    cs = cs + 1;
                if (guess_flat[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v))
                    cg = cg + 1;
            end
            m_int = m_int + min_int(cs, cg);
        end
        a_cnt = CW'(a_int);
        b_cnt = CW'(m_int - a_int);
    end

endmodule

// File: rtl/guess_game_nd.sv
// N-digit bulls-and-cows game: free-running Galois LFSR secret source,
// guess/secret registers, IDLE/PLAY/EVAL/WIN/LOSE flow and try counter.
module guess_game_nd
    import guess_game_nd_pkg::*;
#(
    parameter int                DIGITS    = 4,
    parameter int                DIGIT_W   = 4,
    parameter int                MAX_TRIES = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h0001,
    parameter bit                CHEAT_EN  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             new_game,
    input  logic [DIGIT_W-1:0]               sw,
    input  logic [$clog2(DIGITS)-1:0]        digit_sel,
    input  logic                             load,
    input  logic                             confirm,
    output logic [DIGITS*DIGIT_W-1:0]        guess_flat,
    output logic [$clog2(DIGITS+1)-1:0]      a_cnt,
    output logic [$clog2(DIGITS+1)-1:0]      b_cnt,
    output logic                             result_valid,
    output logic [$clog2(MAX_TRIES+1)-1:0]   try_cnt,
    output logic                             win,
    output logic                             lose,
    output logic [DIGITS*DIGIT_W-1:0]        secret_out
);

    localparam int SW = DIGITS * DIGIT_W;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    state_t                            state;
    logic [LFSR_W-1:0]                 lfsr;
    logic [DIGITS-1:0][DIGIT_W-1:0]    secret;
    logic [DIGITS-1:0][DIGIT_W-1:0]    guess;
    logic [CW-1:0]                     score_a;
    logic [CW-1:0]                     score_b;
    logic [TW-1:0]                     try_next;
    logic                              cheat;

    guess_game_nd_score #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_score (
        .secret_flat (secret),
        .guess_flat  (guess),
        .a_cnt       (score_a),
        .b_cnt       (score_b)
    );

    // Saturating try increment and cheat-code detection.
    always_comb begin
        try_next = (try_cnt == TW'(MAX_TRIES)) ? try_cnt : try_cnt + 1'b1;
        cheat    = CHEAT_EN && (sw == '1);
    end

    // Free-running Galois LFSR; a nonzero seed with the top tap set never reaches zero.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    end

    // Game FSM with registered score, status and guess/secret storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            secret       <= '0;
            guess        <= '0;
            a_cnt        <= '0;
            b_cnt        <= '0;
            try_cnt      <= '0;
            result_valid <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (new_game) begin
                secret  <= lfsr[SW-1:0];
                guess   <= '0;
                a_cnt   <= '0;
                b_cnt   <= '0;
                try_cnt <= '0;
                win     <= 1'b0;
                lose    <= 1'b0;
                state   <= ST_PLAY;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_PLAY: begin
                        // A load always swallows a simultaneous confirm.
                        if (load) begin
                            if (int'(digit_sel) < DIGITS)
                                guess[digit_sel] <= cheat ? secret[digit_sel] : sw;
                        end else if (confirm) begin
                            state <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        a_cnt        <= score_a;
                        b_cnt        <= score_b;
                        result_valid <= 1'b1;
                        try_cnt      <= try_next;
                        if (score_a == CW'(DIGITS)) begin
                            win   <= 1'b1;
                            state <= ST_WIN;
                        end else if (try_next == TW'(MAX_TRIES)) begin
                            lose  <= 1'b1;
                            state <= ST_LOSE;
                        end else begin
                            state <= ST_PLAY;
                        end
                    end
                    ST_WIN, ST_LOSE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign guess_flat = guess;
    assign secret_out = (win || lose) ? secret : '0;

endmodule

// File: tb/tb_guess_game_nd.sv
// Bench for guess_game_nd: scoreboarded results, table of scored guesses,
// hand sequences for same-cycle strobes and reset during evaluation.
module tb_guess_game_nd;

    localparam int          DIGITS    = 4;
    localparam int          DIGIT_W   = 4;
    localparam int          MAX_TRIES = 3;
    localparam int          LFSR_W    = 32;
    // A lone top tap turns the Galois step into a rotate, so the low 16 bits
    // cycle through 0x4321 and 0x3211 within 32 clocks.
    localparam logic [31:0] TAPS      = 32'h8000_0000;
    localparam logic [31:0] SEED      = 32'h3211_4321;

    logic        clk;
    logic        rst;
    logic        new_game;
    logic [3:0]  sw;
    logic [1:0]  digit_sel;
    logic        load;
    logic        confirm;
    logic [15:0] guess_flat;
    logic [2:0]  a_cnt;
    logic [2:0]  b_cnt;
    logic        result_valid;
    logic [1:0]  try_cnt;
    logic        win;
    logic        lose;
    logic [15:0] secret_out;

    guess_game_nd #(
        .DIGITS    (DIGITS),
        .DIGIT_W   (DIGIT_W),
        .MAX_TRIES (MAX_TRIES),
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (TAPS),
        .LFSR_SEED (SEED),
        .CHEAT_EN  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .sw           (sw),
        .digit_sel    (digit_sel),
        .load         (load),
        .confirm      (confirm),
        .guess_flat   (guess_flat),
        .a_cnt        (a_cnt),
        .b_cnt        (b_cnt),
        .result_valid (result_valid),
        .try_cnt      (try_cnt),
        .win          (win),
        .lose         (lose),
        .secret_out   (secret_out)
    );

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [15:0] secret;
        logic [15:0] guess;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [1:0]  tries;
        logic        win;
        logic        lose;
    } vec_t;

    exp_t        q[$];
    vec_t        tv[6];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rv_count = 0;
    int          cyc = 0;
    logic [31:0] m_lfsr = SEED;
    logic [15:0] exp_secret;
    int          rv_before;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR, stepped exactly like the hardware source.
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: every result_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            rv_count++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result_valid: got a=%0d b=%0d expected no result", a_cnt, b_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("a_cnt", 32'(a_cnt), 32'(e.a));
                chk("b_cnt", 32'(b_cnt), 32'(e.b));
                chk("result_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int sel, input logic [3:0] val);
        digit_sel = 2'(sel);
        sw        = val;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    task automatic load_guess(input logic [15:0] g);
        for (int i = 0; i < DIGITS; i++) do_load(i, g[i*4 +: 4]);
    endtask

    task automatic cheat_all();
        for (int i = 0; i < DIGITS; i++) do_load(i, 4'hF);
    endtask

    task automatic wait_results();
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL result_timeout: got no result_valid within 10 cycles, expected %0d results", q.size());
            q.delete();
        end
    endtask

    task automatic do_confirm(input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.cyc = cyc + 2;
        q.push_back(e);
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        wait_results();
    endtask

    task automatic start_game(input logic [15:0] target);
        int n = 0;
        while (m_lfsr[15:0] != target && n < 64) begin
            tick();
            n++;
        end
        chk("lfsr_reaches_target", 32'(m_lfsr[15:0]), 32'(target));
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("new_game_try_cnt", 32'(try_cnt), 32'd0);
        chk("new_game_guess", 32'(guess_flat), 32'd0);
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0; sw = '0; digit_sel = '0; load = 1'b0; confirm = 1'b0;
        tv[0] = '{16'h4321, 16'h5231, 3'd1, 3'd2, 2'd1, 1'b0, 1'b0};
        tv[1] = '{16'h4321, 16'h1234, 3'd0, 3'd4, 2'd2, 1'b0, 1'b0};
        tv[2] = '{16'h4321, 16'h4321, 3'd4, 3'd0, 2'd3, 1'b1, 1'b0};
        tv[3] = '{16'h3211, 16'h1121, 3'd1, 3'd2, 2'd1, 1'b0, 1'b0};
        tv[4] = '{16'h3211, 16'h3333, 3'd1, 3'd0, 2'd2, 1'b0, 1'b0};
        tv[5] = '{16'h3211, 16'h1132, 3'd0, 3'd4, 2'd3, 1'b0, 1'b1};

        // Reset, then strobes in IDLE must do nothing.
        tick(); tick();
        rst = 1'b0;
        do_load(0, 4'h5);
        confirm = 1'b1; tick(); confirm = 1'b0;
        tick(); tick(); tick();
        chk("idle_guess", 32'(guess_flat), 32'd0);
        chk("idle_a", 32'(a_cnt), 32'd0);
        chk("idle_b", 32'(b_cnt), 32'd0);
        chk("idle_try", 32'(try_cnt), 32'd0);
        chk("idle_win", 32'(win), 32'd0);
        chk("idle_lose", 32'(lose), 32'd0);
        chk("idle_secret_out", 32'(secret_out), 32'd0);
        chk("idle_no_result", 32'(rv_count), 32'd0);

        // Table of scored guesses across two games.
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || tv[i].secret != tv[i-1].secret) begin
                start_game(tv[i].secret);
                cheat_all();
                chk("cheat_learns_secret", 32'(guess_flat), 32'(tv[i].secret));
            end
            load_guess(tv[i].guess);
            chk("loaded_guess", 32'(guess_flat), 32'(tv[i].guess));
            do_confirm(tv[i].a, tv[i].b);
            chk("try_cnt", 32'(try_cnt), 32'(tv[i].tries));
            chk("win", 32'(win), 32'(tv[i].win));
            chk("lose", 32'(lose), 32'(tv[i].lose));
            chk("secret_out", 32'(secret_out),
                (tv[i].win || tv[i].lose) ? 32'(tv[i].secret) : 32'd0);
            if (i == 2) begin
                // WIN freezes everything except new_game.
                rv_before = rv_count;
                do_load(0, 4'h7);
                confirm = 1'b1; tick(); confirm = 1'b0;
                tick(); tick(); tick();
                chk("win_no_rescore", 32'(rv_count), 32'(rv_before));
                chk("win_try_frozen", 32'(try_cnt), 32'd3);
                chk("win_guess_held", 32'(guess_flat), 32'h4321);
                chk("win_a_held", 32'(a_cnt), 32'd4);
                chk("win_still", 32'(win), 32'd1);
            end
        end

        // LOSE then new_game clears status.
        rv_before = rv_count;
        confirm = 1'b1; tick(); confirm = 1'b0;
        tick(); tick();
        chk("lose_no_rescore", 32'(rv_count), 32'(rv_before));
        exp_secret = m_lfsr[15:0];
        new_game = 1'b1; tick(); new_game = 1'b0;
        chk("regame_try", 32'(try_cnt), 32'd0);
        chk("regame_lose", 32'(lose), 32'd0);
        chk("regame_a", 32'(a_cnt), 32'd0);
        chk("regame_secret_out", 32'(secret_out), 32'd0);

        // new_game and confirm together: new game wins, nothing scored.
        rv_before = rv_count;
        exp_secret = m_lfsr[15:0];
        new_game = 1'b1; confirm = 1'b1; tick(); new_game = 1'b0; confirm = 1'b0;
        tick(); tick(); tick();
        chk("newgame_confirm_no_result", 32'(rv_count), 32'(rv_before));
        chk("newgame_confirm_win", 32'(win), 32'd0);

        // load and confirm together: guess written, nothing scored.
        digit_sel = 2'd2; sw = 4'h6; load = 1'b1; confirm = 1'b1;
        tick();
        load = 1'b0; confirm = 1'b0;
        tick(); tick(); tick();
        chk("load_confirm_guess", 32'(guess_flat), 32'h0600);
        chk("load_confirm_no_result", 32'(rv_count), 32'(rv_before));

        // Still in PLAY: cheat to the model-predicted secret and win.
        cheat_all();
        chk("predicted_secret", 32'(guess_flat), 32'(exp_secret));
        do_confirm(3'd4, 3'd0);
        chk("cheat_win", 32'(win), 32'd1);
        chk("cheat_win_try", 32'(try_cnt), 32'd1);
        chk("cheat_win_secret_out", 32'(secret_out), 32'(exp_secret));

        // Reset landing on the EVAL cycle discards the result.
        new_game = 1'b1; tick(); new_game = 1'b0;
        do_load(1, 4'h9);
        rv_before = rv_count;
        confirm = 1'b1; tick(); confirm = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        chk("rst_eval_no_result", 32'(rv_count), 32'(rv_before));
        chk("rst_eval_guess", 32'(guess_flat), 32'd0);
        chk("rst_eval_a", 32'(a_cnt), 32'd0);
        chk("rst_eval_b", 32'(b_cnt), 32'd0);
        chk("rst_eval_try", 32'(try_cnt), 32'd0);
        chk("rst_eval_win_lose", 32'({win, lose}), 32'd0);
        chk("rst_eval_secret_out", 32'(secret_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

endmodule
